// File: rtl/datapath_bus_unit_if.sv
// Control/bus bundle between the microcoded controller (plus its memories) and the datapath.
// master: controller side, drives the per-cycle control words and the memory read data.
// slave : datapath side, returns the instruction, z, the bus error flag and the memory addresses.
interface datapath_bus_unit_if #(
  parameter int DATA_W = 16,
  parameter int DM_AW  = 8,
  parameter int IM_AW  = 8
);
  logic [3:0]        read_en;
  logic [15:0]       write_en;
  logic [15:0]       inc_en;
  logic [15:0]       clr_en;
  logic [2:0]        alu_op;
  logic [5:0]        instruction;
  logic [DATA_W-1:0] z;
  logic [DM_AW-1:0]  dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_we;
  logic [DATA_W-1:0] dm_rdata;
  logic [IM_AW-1:0]  im_addr;
  logic [DATA_W-1:0] im_rdata;
  logic              bus_err;

  modport master (
    output read_en, write_en, inc_en, clr_en, alu_op, dm_rdata, im_rdata,
    input  instruction, z, dm_addr, dm_wdata, dm_we, im_addr, bus_err
  );

  modport slave (
    input  read_en, write_en, inc_en, clr_en, alu_op, dm_rdata, im_rdata,
    output instruction, z, dm_addr, dm_wdata, dm_we, im_addr, bus_err
  );
endinterface

// File: rtl/datapath_bus_unit.sv
// Datapath responder for the microcoded controller: register bank, shared bus,
// ALU and the data/instruction memory ports.
// Optional feature macro DP_MULT_EN: when defined, alu_op 3 multiplies AC*R;
// when undefined no multiplier exists, alu_op 3 into AC holds AC and flags bus_err.
module datapath_bus_unit #(
  parameter int DATA_W = 16,
  parameter int DM_AW  = 8,
  parameter int IM_AW  = 8
) (
  input logic clk,
  input logic rst,
  datapath_bus_unit_if.slave bus
);

  logic [DATA_W-1:0] pc, ar, ir, ac, r, r1, r2, r3, r4;
  logic [DATA_W-1:0] bus_q, bus_src, wdata, alu_result;
  logic              z_q, bus_err_q, illegal_rd, alu_hold;

  // Bus source mux; illegal codes drive zero and raise illegal_rd
  always_comb begin
    bus_src    = '0;
    illegal_rd = 1'b0;
    case (bus.read_en)
      4'd0:    bus_src = '0;
      4'd1:    bus_src = pc;
      4'd2:    bus_src = ar;
      4'd4:    bus_src = ir;
      4'd5:    bus_src = ac;
      4'd6:    bus_src = r;
      4'd7:    bus_src = r1;
      4'd8:    bus_src = r2;
      4'd9:    bus_src = r3;
      4'd10:   bus_src = r4;
      4'd12:   bus_src = bus.dm_rdata;
      4'd13:   bus_src = bus.im_rdata;
      default: illegal_rd = 1'b1;
    endcase
  end

  // Same-cycle transfers take the live bus; split microsteps reuse the latched value
  assign wdata = (bus.read_en != 4'd0) ? bus_src : bus_q;

  // ALU with A = AC, B = R, results truncated to DATA_W
  always_comb begin
    alu_result = ac;
    alu_hold   = 1'b0;
    case (bus.alu_op)
      3'd1: alu_result = ac + r;
      3'd2: alu_result = ac - r;
`ifdef DP_MULT_EN
      3'd3: alu_result = ac * r;
`else
      3'd3: alu_hold = 1'b1;
`endif
      3'd4: alu_result = ac << r[3:0];
      default: alu_result = ac;
    endcase
  end

  // Bus latch: captures the bus whenever a source is selected
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       bus_q <= '0;
    else if (bus.read_en != 4'd0)  bus_q <= bus_src;
  end

  // Program counter: clear > load > increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  pc <= '0;
    else if (bus.clr_en[1])   pc <= '0;
    else if (bus.write_en[1]) pc <= wdata;
    else if (bus.inc_en[1])   pc <= pc + DATA_W'(1);
  end

  // Address register: clear > load
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  ar <= '0;
    else if (bus.clr_en[2])   ar <= '0;
    else if (bus.write_en[2]) ar <= wdata;
  end

  // Accumulator: clear > ALU load > bus load > increment; unsupported ALU op holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   ac <= '0;
    else if (bus.clr_en[4])    ac <= '0;
    else if (bus.write_en[12]) begin
      if (!alu_hold)           ac <= alu_result;
    end
    else if (bus.write_en[4])  ac <= wdata;
    else if (bus.inc_en[4])    ac <= ac + DATA_W'(1);
  end

  // Load-only registers: IR, R and R1-R4
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir <= '0;
      r  <= '0;
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
      r4 <= '0;
    end else begin
      if (bus.write_en[3])  ir <= wdata;
      if (bus.write_en[5])  r  <= wdata;
      if (bus.write_en[10]) r1 <= wdata;
      if (bus.write_en[9])  r2 <= wdata;
      if (bus.write_en[8])  r3 <= wdata;
      if (bus.write_en[7])  r4 <= wdata;
    end
  end

  // z lags AC by one cycle; bus_err is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q       <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      z_q <= (ac == '0);
      if (illegal_rd || (bus.write_en[12] && alu_hold)) bus_err_q <= 1'b1;
    end
  end

  assign bus.instruction = ir[5:0];
  assign bus.z           = {{(DATA_W-1){1'b0}}, z_q};
  assign bus.dm_addr     = ar[DM_AW-1:0];
  assign bus.dm_wdata    = wdata;
  // Strobe is masked during reset so an in-flight store cannot land
  assign bus.dm_we       = bus.write_en[11] & ~rst;
  assign bus.im_addr     = pc[IM_AW-1:0];
  assign bus.bus_err     = bus_err_q;

  logic unused_bits;
  assign unused_bits = ^{bus.write_en[15:13], bus.write_en[6], bus.write_en[0],
                         bus.inc_en[15:5], bus.inc_en[3:2], bus.inc_en[0],
                         bus.clr_en[15:5], bus.clr_en[3], bus.clr_en[0]};

endmodule

// File: tb/tb_datapath_bus_unit.sv
// Directed bench for datapath_bus_unit: fetch, loads/stores, ALU, z/inc/clr,
// illegal bus codes and asynchronous reset.
module tb_datapath_bus_unit;

  localparam logic [15:0] W_PC = 16'h0002, W_AR = 16'h0004, W_IR = 16'h0008,
                          W_AC = 16'h0010, W_R  = 16'h0020, W_R4 = 16'h0080,
                          W_R3 = 16'h0100, W_R2 = 16'h0200, W_R1 = 16'h0400,
                          W_DM = 16'h0800, W_ALU = 16'h1000;
  localparam logic [15:0] B_PC = 16'h0002, B_AR = 16'h0004, B_AC = 16'h0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] im_val = 16'h0000;
  logic [15:0] dm_mem [0:255];
  logic [15:0] v;
  int n_vec = 0;
  int n_err = 0;

  datapath_bus_unit_if intf ();

  datapath_bus_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  always #5 clk = ~clk;

  assign intf.im_rdata = im_val;
  assign intf.dm_rdata = dm_mem[intf.dm_addr];

  // Data memory model: reset preloads word 5, DUT stores on dm_we
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) dm_mem[i] <= 16'h0000;
      dm_mem[5] <= 16'h00AA;
    end else if (intf.dm_we) begin
      dm_mem[intf.dm_addr] <= intf.dm_wdata;
    end
  end

  task automatic cyc(input logic [3:0] rd, input logic [15:0] wr, input logic [15:0] inc,
                     input logic [15:0] clr, input logic [2:0] op);
    intf.read_en  = rd;
    intf.write_en = wr;
    intf.inc_en   = inc;
    intf.clr_en   = clr;
    intf.alu_op   = op;
    @(posedge clk);
    #1;
    intf.read_en  = 4'd0;
    intf.write_en = 16'h0;
    intf.inc_en   = 16'h0;
    intf.clr_en   = 16'h0;
    intf.alu_op   = 3'd0;
  endtask

  // Puts a register on the bus between edges and reads it through dm_wdata
  task automatic peek(input logic [3:0] code, output logic [15:0] val);
    intf.read_en = code;
    #1;
    val = intf.dm_wdata;
    intf.read_en = 4'd0;
  endtask

  task automatic load(input logic [15:0] mask, input logic [15:0] val);
    im_val = val;
    cyc(4'd13, mask, 16'h0, 16'h0, 3'd0);
  endtask

  task automatic test_reset;
    #12;
    n_vec++; if (intf.instruction !== 6'd0) begin n_err++; $display("FAIL rst_instr: got %h expected 00", intf.instruction); end
    n_vec++; if (intf.z !== 16'h0000) begin n_err++; $display("FAIL rst_z: got %h expected 0000", intf.z); end
    n_vec++; if (intf.bus_err !== 1'b0) begin n_err++; $display("FAIL rst_bus_err: got %b expected 0", intf.bus_err); end
    n_vec++; if (intf.im_addr !== 8'h00 || intf.dm_addr !== 8'h00) begin n_err++; $display("FAIL rst_addr: got im %h dm %h expected 00 00", intf.im_addr, intf.dm_addr); end
    n_vec++; if (intf.dm_we !== 1'b0) begin n_err++; $display("FAIL rst_dm_we: got %b expected 0", intf.dm_we); end
    peek(4'd5, v);
    n_vec++; if (v !== 16'h0000) begin n_err++; $display("FAIL rst_ac: got %h expected 0000", v); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    im_val = 16'h0013;
    cyc(4'd13, W_IR, 16'h0, 16'h0, 3'd0);
    n_vec++; if (intf.instruction !== 6'd19) begin n_err++; $display("FAIL fetch_instr: got %0d expected 19", intf.instruction); end
    peek(4'd4, v);
    n_vec++; if (v !== 16'h0013) begin n_err++; $display("FAIL fetch_ir: got %h expected 0013", v); end
    cyc(4'd0, 16'h0, B_PC, 16'h0, 3'd0);
    n_vec++; if (intf.im_addr !== 8'h01) begin n_err++; $display("FAIL fetch_pc_inc: got %h expected 01", intf.im_addr); end
  endtask

  task automatic test_split_load;
    load(W_AC, 16'h0005);
    cyc(4'd5, 16'h0, 16'h0, 16'h0, 3'd0);
    cyc(4'd0, W_AR, 16'h0, 16'h0, 3'd0);
    n_vec++; if (intf.dm_addr !== 8'h05) begin n_err++; $display("FAIL split_ar: got %h expected 05", intf.dm_addr); end
    cyc(4'd12, 16'h0, 16'h0, 16'h0, 3'd0);
    cyc(4'd0, W_AC, 16'h0, 16'h0, 3'd0);
    peek(4'd5, v);
    n_vec++; if (v !== 16'h00AA) begin n_err++; $display("FAIL split_ac: got %h expected 00aa", v); end
  endtask

  task automatic test_store;
    load(W_AC, 16'h1234);
    cyc(4'd5, W_R1, 16'h0, 16'h0, 3'd0);
    peek(4'd7, v);
    n_vec++; if (v !== 16'h1234) begin n_err++; $display("FAIL move_r1: got %h expected 1234", v); end
    load(W_R2, 16'h2222);
    load(W_R3, 16'h3333);
    load(W_R4, 16'h4444);
    load(W_R, 16'h5555);
    peek(4'd8, v);
    n_vec++; if (v !== 16'h2222) begin n_err++; $display("FAIL move_r2: got %h expected 2222", v); end
    peek(4'd9, v);
    n_vec++; if (v !== 16'h3333) begin n_err++; $display("FAIL move_r3: got %h expected 3333", v); end
    peek(4'd10, v);
    n_vec++; if (v !== 16'h4444) begin n_err++; $display("FAIL move_r4: got %h expected 4444", v); end
    peek(4'd6, v);
    n_vec++; if (v !== 16'h5555) begin n_err++; $display("FAIL move_r: got %h expected 5555", v); end
    cyc(4'd5, 16'h0, 16'h0, 16'h0, 3'd0);
    intf.write_en = W_DM;
    #1;
    n_vec++; if (intf.dm_we !== 1'b1 || intf.dm_wdata !== 16'h1234 || intf.dm_addr !== 8'h05) begin n_err++; $display("FAIL store_port: got we %b data %h addr %h expected 1 1234 05", intf.dm_we, intf.dm_wdata, intf.dm_addr); end
    @(posedge clk);
    #1;
    intf.write_en = 16'h0;
    #1;
    n_vec++; if (intf.dm_we !== 1'b0) begin n_err++; $display("FAIL store_pulse: got %b expected 0", intf.dm_we); end
    n_vec++; if (dm_mem[5] !== 16'h1234) begin n_err++; $display("FAIL store_mem: got %h expected 1234", dm_mem[5]); end
    cyc(4'd12, W_R3, 16'h0, 16'h0, 3'd0);
    peek(4'd9, v);
    n_vec++; if (v !== 16'h1234) begin n_err++; $display("FAIL dm_to_r3: got %h expected 1234", v); end
  endtask

  task automatic test_alu;
    load(W_AC, 16'h0007); load(W_R, 16'h0003);
    cyc(4'd0, W_ALU, 16'h0, 16'h0, 3'd1);
    peek(4'd5, v);
    n_vec++; if (v !== 16'h000A) begin n_err++; $display("FAIL alu_add: got %h expected 000a", v); end
    load(W_AC, 16'h0003); load(W_R, 16'h0007);
    cyc(4'd0, W_ALU, 16'h0, 16'h0, 3'd2);
    peek(4'd5, v);
    n_vec++; if (v !== 16'hFFFC) begin n_err++; $display("FAIL alu_sub: got %h expected fffc", v); end
    load(W_AC, 16'h0001); load(W_R, 16'h0004);
    cyc(4'd0, W_ALU, 16'h0, 16'h0, 3'd4);
    peek(4'd5, v);
    n_vec++; if (v !== 16'h0010) begin n_err++; $display("FAIL alu_lshift: got %h expected 0010", v); end
    cyc(4'd0, W_ALU, 16'h0, 16'h0, 3'd0);
    peek(4'd5, v);
    n_vec++; if (v !== 16'h0010) begin n_err++; $display("FAIL alu_pass: got %h expected 0010", v); end
    load(W_AC, 16'hFFFF); load(W_R, 16'h0002);
    cyc(4'd0, W_ALU, 16'h0, 16'h0, 3'd1);
    peek(4'd5, v);
    n_vec++; if (v !== 16'h0001) begin n_err++; $display("FAIL alu_add_wrap: got %h expected 0001", v); end
  endtask

  task automatic test_z_inc_clr;
    load(W_AC, 16'hFFFF);
    cyc(4'd0, 16'h0, B_AC, 16'h0, 3'd0);
    n_vec++; if (intf.z !== 16'h0000) begin n_err++; $display("FAIL z_lag: got %h expected 0000", intf.z); end
    peek(4'd5, v);
    n_vec++; if (v !== 16'h0000) begin n_err++; $display("FAIL ac_inc_wrap: got %h expected 0000", v); end
    cyc(4'd0, 16'h0, 16'h0, 16'h0, 3'd0);
    n_vec++; if (intf.z !== 16'h0001) begin n_err++; $display("FAIL z_set: got %h expected 0001", intf.z); end
    load(W_AC, 16'h0005);
    cyc(4'd0, 16'h0, B_AC, B_AC, 3'd0);
    peek(4'd5, v);
    n_vec++; if (v !== 16'h0000) begin n_err++; $display("FAIL clr_over_inc: got %h expected 0000", v); end
    im_val = 16'h0009;
    cyc(4'd13, W_AC, B_AC, 16'h0, 3'd0);
    peek(4'd5, v);
    n_vec++; if (v !== 16'h0009) begin n_err++; $display("FAIL write_over_inc: got %h expected 0009", v); end
    cyc(4'd13, W_AC, 16'h0, B_AC, 3'd0);
    peek(4'd5, v);
    n_vec++; if (v !== 16'h0000) begin n_err++; $display("FAIL clr_over_write: got %h expected 0000", v); end
    load(W_PC, 16'hFFFF);
    cyc(4'd0, 16'h0, B_PC, 16'h0, 3'd0);
    peek(4'd1, v);
    n_vec++; if (v !== 16'h0000) begin n_err++; $display("FAIL pc_inc_wrap: got %h expected 0000", v); end
    load(W_PC, 16'h0003);
    load(W_AR, 16'h0044);
    cyc(4'd0, 16'h0, 16'h0, B_PC | B_AR, 3'd0);
    n_vec++; if (intf.im_addr !== 8'h00 || intf.dm_addr !== 8'h00) begin n_err++; $display("FAIL clr_pc_ar: got im %h dm %h expected 00 00", intf.im_addr, intf.dm_addr); end
  endtask

  task automatic test_illegal;
    n_vec++; if (intf.bus_err !== 1'b0) begin n_err++; $display("FAIL err_clean: got %b expected 0", intf.bus_err); end
    load(W_AC, 16'h0007);
    cyc(4'd14, W_AC, 16'h0, 16'h0, 3'd0);
    n_vec++; if (intf.bus_err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b expected 1", intf.bus_err); end
    peek(4'd5, v);
    n_vec++; if (v !== 16'h0000) begin n_err++; $display("FAIL err_bus_zero: got %h expected 0000", v); end
    for (int k = 0; k < 3; k++) cyc(4'd0, 16'h0, 16'h0, 16'h0, 3'd0);
    n_vec++; if (intf.bus_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", intf.bus_err); end
  endtask

  task automatic test_reset_mid;
    load(W_PC, 16'h0003);
    load(W_IR, 16'h002A);
    load(W_AC, 16'h0055);
    cyc(4'd0, W_AR, 16'h0, 16'h0, 3'd0);
    intf.read_en  = 4'd5;
    intf.write_en = W_R2 | W_DM;
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (intf.im_addr !== 8'h00 || intf.dm_addr !== 8'h00) begin n_err++; $display("FAIL mid_rst_addr: got im %h dm %h expected 00 00", intf.im_addr, intf.dm_addr); end
    n_vec++; if (intf.instruction !== 6'd0) begin n_err++; $display("FAIL mid_rst_instr: got %h expected 00", intf.instruction); end
    n_vec++; if (intf.bus_err !== 1'b0 || intf.z !== 16'h0000) begin n_err++; $display("FAIL mid_rst_flags: got err %b z %h expected 0 0000", intf.bus_err, intf.z); end
    n_vec++; if (intf.dm_we !== 1'b0) begin n_err++; $display("FAIL mid_rst_dm_we: got %b expected 0", intf.dm_we); end
    @(posedge clk);
    #1;
    intf.read_en  = 4'd0;
    intf.write_en = 16'h0;
    peek(4'd8, v);
    n_vec++; if (v !== 16'h0000) begin n_err++; $display("FAIL mid_rst_r2: got %h expected 0000", v); end
    peek(4'd5, v);
    n_vec++; if (v !== 16'h0000) begin n_err++; $display("FAIL mid_rst_ac: got %h expected 0000", v); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mult;
    load(W_AC, 16'h0100); load(W_R, 16'h0100);
    cyc(4'd0, W_ALU, 16'h0, 16'h0, 3'd3);
    peek(4'd5, v);
`ifdef DP_MULT_EN
    n_vec++; if (v !== 16'h0000) begin n_err++; $display("FAIL mult_trunc: got %h expected 0000", v); end
    n_vec++; if (intf.bus_err !== 1'b0) begin n_err++; $display("FAIL mult_err: got %b expected 0", intf.bus_err); end
    load(W_AC, 16'h0003); load(W_R, 16'h0005);
    cyc(4'd0, W_ALU, 16'h0, 16'h0, 3'd3);
    peek(4'd5, v);
    n_vec++; if (v !== 16'h000F) begin n_err++; $display("FAIL mult_small: got %h expected 000f", v); end
`else
    n_vec++; if (v !== 16'h0100) begin n_err++; $display("FAIL mult_hold: got %h expected 0100", v); end
    n_vec++; if (intf.bus_err !== 1'b1) begin n_err++; $display("FAIL mult_err: got %b expected 1", intf.bus_err); end
`endif
  endtask

  initial begin
    intf.read_en  = 4'd0;
    intf.write_en = 16'h0;
    intf.inc_en   = 16'h0;
    intf.clr_en   = 16'h0;
    intf.alu_op   = 3'd0;
    test_reset();
    test_fetch();
    test_split_load();
    test_store();
    test_alu();
    test_z_inc_clr();
    test_illegal();
    test_reset_mid();
    test_mult();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
